// File: rtl/softmax_pkg.sv
// Shared constants, exp() lookup table and FSM encoding for the fixed-point softmax engine.
package softmax_pkg;

   localparam int unsigned LUT_FRAC  = 3;
   localparam int unsigned LUT_DEPTH = 64;
   localparam int unsigned LUT_AW    = 6;
   localparam int unsigned EXP_W     = 17;
   localparam int unsigned PROB_W    = 16;
   localparam int unsigned DIV_ITER  = 33;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StExp,
      StDiv,
      StOut
   } state_t;

   // round(65536 * exp(-k/8)), k = 0..63
   localparam logic [EXP_W-1:0] EXP_LUT [LUT_DEPTH] = '{
      17'd65536, 17'd57835, 17'd51039, 17'd45042, 17'd39750, 17'd35079, 17'd30957, 17'd27319,
      17'd24109, 17'd21276, 17'd18776, 17'd16570, 17'd14623, 17'd12905, 17'd11388, 17'd10050,
      17'd8869,  17'd7827,  17'd6907,  17'd6096,  17'd5380,  17'd4747,  17'd4190,  17'd3697,
      17'd3263,  17'd2879,  17'd2541,  17'd2243,  17'd1979,  17'd1746,  17'd1541,  17'd1360,
      17'd1200,  17'd1059,  17'd935,   17'd825,   17'd728,   17'd642,   17'd567,   17'd500,
      17'd442,   17'd390,   17'd344,   17'd303,   17'd268,   17'd236,   17'd209,   17'd184,
      17'd162,   17'd143,   17'd127,   17'd112,   17'd99,    17'd87,    17'd77,    17'd68,
      17'd60,    17'd53,    17'd47,    17'd41,    17'd36,    17'd32,    17'd28,    17'd25
   };

endpackage

// File: rtl/recip_div.sv
// Serial restoring divider computing floor(2^32 / divisor), one quotient bit per cycle.
module recip_div
   import softmax_pkg::*;
#(
   parameter int unsigned DIV_W = 21
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DIV_W-1:0] divisor,
   output logic             done,
   output logic [EXP_W-1:0] quotient
);

   localparam int unsigned IT_W = $clog2(DIV_ITER + 1);
   localparam logic [IT_W-1:0] LAST_IT = IT_W'(DIV_ITER - 1);

   logic [DIV_W-1:0] r_divisor;
   logic [DIV_W-1:0] r_rem;
   logic [EXP_W-1:0] r_quo;
   logic [IT_W-1:0]  r_iter;
   logic             r_run;

   logic             w_bit;
   logic [DIV_W:0]   w_shift;
   logic             w_ge;
   logic [DIV_W-1:0] w_rem_next;

   // The dividend is 2^32, so only the first bit shifted in is a one.
   assign w_bit      = (r_iter == '0);
   assign w_shift    = {r_rem, w_bit};
   assign w_ge       = (w_shift >= {1'b0, r_divisor});
   assign w_rem_next = w_ge ? DIV_W'(w_shift - {1'b0, r_divisor}) : DIV_W'(w_shift);

   assign done     = r_run && (r_iter == LAST_IT);
   assign quotient = r_quo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_divisor <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_iter    <= '0;
         r_run     <= 1'b0;
      end else if (start) begin
         r_divisor <= divisor;
         r_rem     <= '0;
         r_quo     <= '0;
         r_iter    <= '0;
         r_run     <= 1'b1;
      end else if (r_run) begin
         // Divisor >= 2^16 keeps the quotient within EXP_W bits; bits shifted out are zero.
         r_rem  <= w_rem_next;
         r_quo  <= {r_quo[EXP_W-2:0], w_ge};
         r_iter <= r_iter + IT_W'(1);
         if (done) r_run <= 1'b0;
      end
   end

endmodule

// File: rtl/softmax_fxp.sv
// Streaming fixed-point softmax: buffer scores, exp(x - max) via LUT, one reciprocal of the
// sum, then stream Q0.16 probabilities with valid/ready on both sides.
module softmax_fxp
   import softmax_pkg::*;
#(
   parameter int unsigned LEN    = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned FRAC_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROB_W-1:0] out_data,
   output logic              out_last,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(LEN + 1);
   localparam int unsigned IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam int unsigned SUM_W = EXP_W + $clog2(LEN);
   localparam int unsigned D_W   = DATA_W + 1;
   localparam int unsigned PRD_W = 2 * EXP_W;
   localparam int unsigned SCL_W = PRD_W - PROB_W;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

   state_t r_state, w_state_next;

   logic [DATA_W-1:0] r_buf  [LEN];
   logic [EXP_W-1:0]  r_ebuf [LEN];
   logic [DATA_W-1:0] r_max;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_n;
   logic [CNT_W-1:0]  r_pos;
   logic [SUM_W-1:0]  r_sum;

   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_close;
   logic              w_pos_last;
   logic [IDX_W-1:0]  w_wr_idx;
   logic [IDX_W-1:0]  w_rd_idx;
   logic [DATA_W-1:0] w_rd_val;
   logic [D_W-1:0]    w_diff;
   logic [D_W-1:0]    w_lut_idx;
   logic [EXP_W-1:0]  w_e;
   logic [SUM_W-1:0]  w_sum_next;
   logic              w_div_start;
   logic              w_div_done;
   logic [EXP_W-1:0]  w_recip;
   logic [SCL_W-1:0]  w_scaled;

   assign in_ready  = (r_state == StIdle) || (r_state == StLoad);
   assign out_valid = (r_state == StOut);
   assign busy      = (r_state != StIdle);

   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = out_valid && out_ready;
   assign w_close    = in_last || (r_cnt == LAST_CNT);
   assign w_pos_last = (r_pos == r_n - CNT_W'(1));
   assign w_wr_idx   = r_cnt[IDX_W-1:0];
   assign w_rd_idx   = r_pos[IDX_W-1:0];
   assign w_rd_val   = r_buf[w_rd_idx];

   // Max minus element is never negative; one extra bit holds the full range.
   assign w_diff     = {r_max[DATA_W-1], r_max} - {w_rd_val[DATA_W-1], w_rd_val};
   assign w_lut_idx  = w_diff >> (FRAC_W - LUT_FRAC);
   assign w_e        = (w_lut_idx < D_W'(LUT_DEPTH)) ? EXP_LUT[w_lut_idx[LUT_AW-1:0]] : '0;
   assign w_sum_next = r_sum + SUM_W'(w_e);

   assign w_scaled = SCL_W'((PRD_W'(r_ebuf[w_rd_idx]) * PRD_W'(w_recip)) >> PROB_W);
   assign out_data = !out_valid ? '0 :
                     (|w_scaled[SCL_W-1:PROB_W]) ? '1 : w_scaled[PROB_W-1:0];
   assign out_last = out_valid && w_pos_last;

   always_comb begin
      w_state_next = r_state;
      w_div_start  = 1'b0;
      unique case (r_state)
         StIdle: if (w_in_fire) w_state_next = w_close ? StExp : StLoad;
         StLoad: if (w_in_fire && w_close) w_state_next = StExp;
         StExp: begin
            if (w_pos_last) begin
               w_state_next = StDiv;
               w_div_start  = 1'b1;
            end
         end
         StDiv:  if (w_div_done) w_state_next = StOut;
         StOut:  if (w_out_fire && w_pos_last) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_n     <= '0;
         r_pos   <= '0;
         r_sum   <= '0;
         r_max   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_in_fire) begin
            r_cnt <= w_close ? '0 : r_cnt + CNT_W'(1);
            if (w_close) r_n <= r_cnt + CNT_W'(1);
            if ((r_state == StIdle) || ($signed(in_data) > $signed(r_max))) r_max <= in_data;
         end
         if (r_state == StIdle) begin
            r_sum <= '0;
         end else if (r_state == StExp) begin
            r_sum <= w_sum_next;
         end
         if ((r_state == StExp) || w_out_fire) begin
            r_pos <= w_pos_last ? '0 : r_pos + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_in_fire) r_buf[w_wr_idx] <= in_data;
      if (r_state == StExp) r_ebuf[w_rd_idx] <= w_e;
   end

   recip_div #(
      .DIV_W(SUM_W)
   ) u_recip_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (w_div_start),
      .divisor  (w_sum_next),
      .done     (w_div_done),
      .quotient (w_recip)
   );

endmodule

// File: tb/tb_softmax_fxp.sv
// Randomized and directed bench for softmax_fxp against a real-arithmetic softmax model.
module tb_softmax_fxp;

   localparam int LEN    = 16;
   localparam int DATA_W = 16;
   localparam int FRAC_W = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_last = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [15:0]       out_data;
   logic              out_last;
   logic              busy;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          lut [64];
   logic [15:0] vec [LEN];
   int          vlen;
   bit          vlast;
   int          exp_p [LEN];

   always #5 clk = ~clk;

   softmax_fxp #(
      .LEN    (LEN),
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   task automatic chk(input string tag, input longint got, input longint want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   // Softmax in plain integer arithmetic: exp via rounded real table, steps of 1/8.
   task automatic model();
      int     mx, d, k;
      int     e [LEN];
      longint sum, recip, p;
      mx = int'($signed(vec[0]));
      for (int i = 1; i < vlen; i++)
         if (int'($signed(vec[i])) > mx) mx = int'($signed(vec[i]));
      sum = 0;
      for (int i = 0; i < vlen; i++) begin
         d    = mx - int'($signed(vec[i]));
         k    = d / (1 << (FRAC_W - 3));
         e[i] = (k < 64) ? lut[k] : 0;
         sum += e[i];
      end
      recip = (longint'(1) << 32) / sum;
      for (int i = 0; i < vlen; i++) begin
         p = (longint'(e[i]) * recip) >> 16;
         exp_p[i] = (p > 65535) ? 65535 : int'(p);
      end
   endtask

   task automatic send();
      for (int i = 0; i < vlen; i++) begin
         in_valid = 1'b1;
         in_data  = vec[i];
         in_last  = vlast && (i == vlen - 1);
         chk("in_ready_load", in_ready, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic receive(input int stall_at, input int stall_len, input bit rnd);
      int k = 0;
      int j = 0;
      int stalled = 0;
      int guard = 0;
      while (!out_valid && k < 200) begin
         chk("in_ready_busy", in_ready, 0);
         @(posedge clk); #1;
         k++;
      end
      chk("latency", k, vlen + 33);
      while (j < vlen && guard < 8 * LEN + 50) begin
         guard++;
         if (rnd) out_ready = ($urandom_range(0, 3) != 0);
         else if (j == stall_at && stalled < stall_len) begin
            out_ready = 1'b0;
            stalled++;
         end else out_ready = 1'b1;
         chk("out_valid", out_valid, 1);
         chk("in_ready_out", in_ready, 0);
         chk("out_data", out_data, exp_p[j]);
         chk("out_last", out_last, j == vlen - 1);
         @(posedge clk); #1;
         if (out_ready) j++;
      end
      chk("out_count", j, vlen);
      out_ready = 1'b0;
      chk("in_ready_after", in_ready, 1);
      chk("out_valid_after", out_valid, 0);
      chk("busy_after", busy, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_last"}, out_last, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic gen_random();
      int span;
      int base;
      vlen  = $urandom_range(1, LEN);
      vlast = (vlen < LEN) ? 1'b1 : 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
         0:       span = 0;
         1:       span = 16;
         2:       span = 512;
         default: span = 65535;
      endcase
      base = $urandom_range(0, 65535);
      for (int i = 0; i < vlen; i++) vec[i] = 16'(base + $urandom_range(0, span));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      for (int k = 0; k < 64; k++)
         lut[k] = $rtoi($floor(65536.0 * $exp(-real'(k) / 8.0) + 0.5));

      #1;
      check_reset_outputs("reset");
      #11 rst_n = 1'b1;
      @(posedge clk); #1;

      vlen = 4; vlast = 1'b1;
      for (int i = 0; i < 4; i++) vec[i] = 16'h0100;
      model(); send(); receive(-1, 0, 1'b0);

      vlen = 1; vlast = 1'b1; vec[0] = 16'h8000;
      model(); send(); receive(-1, 0, 1'b0);

      vlen = 2; vlast = 1'b1; vec[0] = 16'h0000; vec[1] = 16'hF800;
      model(); send(); receive(-1, 0, 1'b0);

      vlen = 2; vlast = 1'b1; vec[0] = 16'h0100; vec[1] = 16'h0000;
      model(); send(); receive(-1, 0, 1'b0);

      vlen = LEN; vlast = 1'b0;
      for (int i = 0; i < LEN; i++) vec[i] = 16'($urandom_range(0, 1023));
      model(); send(); receive(7, 5, 1'b0);

      // Reset pulse while the divider is running.
      vlen = 2; vlast = 1'b1; vec[0] = 16'h0100; vec[1] = 16'h0000;
      model(); send();
      repeat (10) @(posedge clk);
      chk("busy_in_div", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("no_output_after_reset", seen, 0);
      send(); receive(-1, 0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         gen_random();
         model(); send(); receive(-1, 0, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
